gray_ptr_sync: RTL and testbench

//  Parametrised Gray-code pointer for one side of an async FIFO.
//  - Keeps a binary pointer and a registered Gray copy, both ADDR_W+1 bits wide.
//  - Synchronises the opposite domain's Gray pointer through a SYNC_STAGES flop chain.
//  - Produces a registered FULL flag (write side) or EMPTY flag (read side).
//  - Two instances, one per clock domain, form the pointer logic of the FIFO.

---
 rtl/gray_ptr_sync.sv | 89 ++++++++
 tb/tb_gray_ptr_sync.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_sync.sv
// One side of an async-FIFO pointer pair: binary/Gray pointer, remote-pointer synchroniser, full/empty flag.
// Optional occupancy output is built only when GRAY_PTR_LEVEL_EN is defined; otherwise level is tied to 0.
module gray_ptr_sync #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter bit WR_SIDE     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W:0]   remote_gray,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   gray,
  output logic              flag,
  output logic              accept,
  output logic [ADDR_W:0]   level
);

  localparam int P = ADDR_W + 1;

  logic [P-1:0] bin;
  logic [P-1:0] bin_n;
  logic [P-1:0] gray_n;
  logic [P-1:0] rsync;
  logic [P-1:0] sync_q [SYNC_STAGES];
  logic         flag_n;

  assign accept = en & ~flag;
  assign bin_n  = bin + {{(P-1){1'b0}}, accept};
  assign gray_n = bin_n ^ (bin_n >> 1);
  assign rsync  = sync_q[SYNC_STAGES-1];
  assign addr   = bin[ADDR_W-1:0];

  // Local pointer: binary and Gray load together from the same next-state value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= bin_n;
      gray <= gray_n;
    end
  end

  // Remote-pointer synchroniser: plain flop chain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= remote_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Full: remote is exactly one lap behind (top two Gray bits inverted)
  generate
    if (WR_SIDE) begin : g_full
      assign flag_n = (gray_n == {~rsync[P-1:P-2], rsync[P-3:0]});
    end else begin : g_empty
      assign flag_n = (gray_n == rsync);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flag <= (WR_SIDE == 1'b0);
    else      flag <= flag_n;
  end

`ifdef GRAY_PTR_LEVEL_EN
  logic [P-1:0] rbin;
  logic [P-1:0] level_n;

  always_comb begin
    rbin = '0;
    for (int i = 0; i < P; i++) rbin[i] = ^(rsync >> i);
  end

  assign level_n = WR_SIDE ? (bin_n - rbin) : (rbin - bin_n);

  // Occupancy register, same timing as the flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) level <= '0;
    else      level <= level_n;
  end
`else
  assign level = '0;
`endif

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Directed bench for gray_ptr_sync (ADDR_W=2, SYNC_STAGES=2): a write-side and a read-side instance.
// Level expectations follow GRAY_PTR_LEVEL_EN; without it level must stay 0.
module tb_gray_ptr_sync;

`ifdef GRAY_PTR_LEVEL_EN
  localparam bit LVL_ON = 1'b1;
`else
  localparam bit LVL_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       w_en, r_en;
  logic [2:0] w_rg, r_rg;
  logic [1:0] w_addr, r_addr;
  logic [2:0] w_gray, r_gray, w_level, r_level;
  logic       w_flag, r_flag, w_accept, r_accept;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  gray_ptr_sync #(.ADDR_W(2), .SYNC_STAGES(2), .WR_SIDE(1'b1)) u_wr (
    .clk(clk), .rst(rst), .en(w_en), .remote_gray(w_rg),
    .addr(w_addr), .gray(w_gray), .flag(w_flag), .accept(w_accept), .level(w_level)
  );

  gray_ptr_sync #(.ADDR_W(2), .SYNC_STAGES(2), .WR_SIDE(1'b0)) u_rd (
    .clk(clk), .rst(rst), .en(r_en), .remote_gray(r_rg),
    .addr(r_addr), .gray(r_gray), .flag(r_flag), .accept(r_accept), .level(r_level)
  );

  function automatic logic [2:0] lvl(input int v);
    return 3'(v) & {3{LVL_ON}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0; w_rg = '0; r_rg = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0; w_rg = '0; r_rg = '0;
    tick(); tick();
    total++; if (w_addr !== 2'd0) $display("FAIL rst_w_addr got %0h exp 0", w_addr); else passed++;
    total++; if (w_gray !== 3'd0) $display("FAIL rst_w_gray got %0h exp 0", w_gray); else passed++;
    total++; if (w_flag !== 1'b0) $display("FAIL rst_w_full got %0b exp 0", w_flag); else passed++;
    total++; if (r_flag !== 1'b1) $display("FAIL rst_r_empty got %0b exp 1", r_flag); else passed++;
    total++; if (w_level !== 3'd0) $display("FAIL rst_w_level got %0h exp 0", w_level); else passed++;
    total++; if (r_level !== 3'd0) $display("FAIL rst_r_level got %0h exp 0", r_level); else passed++;
    rst = 1'b1;
  endtask

  task automatic test_gray_seq();
    logic [2:0] seq [4];
    seq = '{3'b001, 3'b011, 3'b010, 3'b110};
    w_rg = 3'b000;
    w_en = 1'b1;
    #1;
    total++; if (w_accept !== 1'b1) $display("FAIL seq_accept0 got %0b exp 1", w_accept); else passed++;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (w_gray !== seq[i]) $display("FAIL seq_gray%0d got %03b exp %03b", i, w_gray, seq[i]); else passed++;
      total++; if (w_flag !== (i == 3)) $display("FAIL seq_full%0d got %0b exp %0b", i, w_flag, (i == 3)); else passed++;
      total++; if (w_level !== lvl(i + 1)) $display("FAIL seq_level%0d got %0d exp %0d", i, w_level, lvl(i + 1)); else passed++;
    end
    total++; if (w_accept !== 1'b0) $display("FAIL seq_accept_full got %0b exp 0", w_accept); else passed++;
    tick();
    total++; if (w_gray !== 3'b110) $display("FAIL seq_hold_gray got %03b exp 110", w_gray); else passed++;
    total++; if (w_addr !== 2'd0) $display("FAIL seq_hold_addr got %0d exp 0", w_addr); else passed++;
    total++; if (w_flag !== 1'b1) $display("FAIL seq_hold_full got %0b exp 1", w_flag); else passed++;
    w_en = 1'b0;
  endtask

  task automatic test_wrap();
    logic [2:0] gtab [8];
    logic [2:0] hist [256];
    int         chist [256];
    logic [2:0] prev, g;
    int         cyc, changes, rc;
    gtab = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    do_reset();
    prev = 3'b000; cyc = 0; changes = 0;
    w_en = 1'b1;
    while (changes < 16 && cyc < 200) begin
      tick();
      g = w_gray;
      hist[cyc] = g;
      if (g !== prev) begin
        changes++;
        total++; if ($countones(g ^ prev) != 1) $display("FAIL wrap_onebit%0d got %03b exp one-bit step from %03b", changes, g, prev); else passed++;
        total++; if (g !== gtab[changes % 8]) $display("FAIL wrap_code%0d got %03b exp %03b", changes, g, gtab[changes % 8]); else passed++;
        prev = g;
        if (changes == 16) w_en = 1'b0;
      end
      chist[cyc] = changes;
      rc = (cyc >= 4) ? chist[cyc-4] : 0;
      total++; if (changes - rc > 4 || changes < rc) $display("FAIL wrap_occupancy got %0d exp 0..4", changes - rc); else passed++;
      w_rg = (cyc >= 4) ? hist[cyc-4] : 3'b000;
      cyc++;
    end
    total++; if (changes != 16) $display("FAIL wrap_budget got %0d exp 16 increments", changes); else passed++;
    total++; if (w_gray !== 3'b000) $display("FAIL wrap_final got %03b exp 000", w_gray); else passed++;
  endtask

  task automatic test_empty_latency();
    do_reset();
    total++; if (r_flag !== 1'b1) $display("FAIL lat_empty0 got %0b exp 1", r_flag); else passed++;
    r_rg = 3'b001;
    r_en = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      #1;
      total++; if (r_accept !== 1'b0) $display("FAIL lat_accept%0d got %0b exp 0", k, r_accept); else passed++;
      tick();
      total++; if (r_flag !== 1'b1) $display("FAIL lat_empty%0d got %0b exp 1", k, r_flag); else passed++;
      total++; if (r_gray !== 3'b000) $display("FAIL lat_gray%0d got %03b exp 000", k, r_gray); else passed++;
    end
    r_en = 1'b0;
    tick();
    total++; if (r_flag !== 1'b0) $display("FAIL lat_empty3 got %0b exp 0", r_flag); else passed++;
    total++; if (r_level !== lvl(1)) $display("FAIL lat_level got %0d exp %0d", r_level, lvl(1)); else passed++;
    total++; if (r_gray !== 3'b000) $display("FAIL lat_gray3 got %03b exp 000", r_gray); else passed++;
  endtask

  task automatic test_simultaneous();
    r_en = 1'b1;
    r_rg = 3'b011;
    #1;
    total++; if (r_accept !== 1'b1) $display("FAIL sim_accept got %0b exp 1", r_accept); else passed++;
    tick();
    r_en = 1'b0;
    total++; if (r_flag !== 1'b1) $display("FAIL sim_emptyA got %0b exp 1", r_flag); else passed++;
    total++; if (r_gray !== 3'b001) $display("FAIL sim_gray got %03b exp 001", r_gray); else passed++;
    total++; if (r_addr !== 2'd1) $display("FAIL sim_addr got %0d exp 1", r_addr); else passed++;
    total++; if (r_level !== lvl(0)) $display("FAIL sim_levelA got %0d exp %0d", r_level, lvl(0)); else passed++;
    tick();
    total++; if (r_flag !== 1'b1) $display("FAIL sim_emptyB got %0b exp 1", r_flag); else passed++;
    tick();
    total++; if (r_flag !== 1'b0) $display("FAIL sim_emptyC got %0b exp 0", r_flag); else passed++;
    total++; if (r_level !== lvl(1)) $display("FAIL sim_levelC got %0d exp %0d", r_level, lvl(1)); else passed++;
  endtask

  task automatic test_reset_mid();
    w_rg = 3'b000;
    w_en = 1'b0;
    repeat (3) tick();
    w_en = 1'b1;
    tick();
    total++; if (w_gray !== 3'b001) $display("FAIL mid_pre_gray got %03b exp 001", w_gray); else passed++;
    r_en = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    total++; if (w_gray !== 3'b000) $display("FAIL mid_w_gray got %03b exp 000", w_gray); else passed++;
    total++; if (w_addr !== 2'd0) $display("FAIL mid_w_addr got %0d exp 0", w_addr); else passed++;
    total++; if (w_flag !== 1'b0) $display("FAIL mid_w_full got %0b exp 0", w_flag); else passed++;
    total++; if (w_level !== 3'd0) $display("FAIL mid_w_level got %0d exp 0", w_level); else passed++;
    total++; if (r_gray !== 3'b000) $display("FAIL mid_r_gray got %03b exp 000", r_gray); else passed++;
    total++; if (r_addr !== 2'd0) $display("FAIL mid_r_addr got %0d exp 0", r_addr); else passed++;
    total++; if (r_flag !== 1'b1) $display("FAIL mid_r_empty got %0b exp 1", r_flag); else passed++;
    total++; if (r_level !== 3'd0) $display("FAIL mid_r_level got %0d exp 0", r_level); else passed++;
    tick(); tick();
    total++; if (w_gray !== 3'b000) $display("FAIL mid_hold_w_gray got %03b exp 000", w_gray); else passed++;
    total++; if (r_flag !== 1'b1) $display("FAIL mid_hold_r_empty got %0b exp 1", r_flag); else passed++;
    rst = 1'b1;
    w_en = 1'b0; r_en = 1'b0;
  endtask

  initial begin
    w_en = 1'b0; r_en = 1'b0; w_rg = '0; r_rg = '0;
    test_reset();
    test_gray_seq();
    test_wrap();
    test_empty_latency();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
